// File: rtl/clock_display_pkg.sv
// Shared display constants: segment patterns, digit index type, digit count.
// Latency: none (definitions and one pure combinational helper).
// Backpressure: not applicable.
package clock_display_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [1:0] digit_idx_t;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Non-decimal codes light nothing rather than aliasing onto a real digit
    function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
        logic [6:0] pat;
        pat = 7'h00;
        if (digit <= 4'd9) begin
            pat = SEG_DIGIT[digit];
        end
        return pat;
    endfunction

endpackage

// File: rtl/seg7_bin2dig.sv
// Splits a 0..63 binary value into decimal tens and ones digits.
// Latency: purely combinational.
// Backpressure: not applicable.
module seg7_bin2dig (
    input  logic [5:0] value_i,
    output logic [2:0] tens_o,
    output logic [3:0] ones_o
);

    // Constant divide/modulo by ten; the input range keeps tens within 0..6
    always_comb begin
        tens_o = 3'(value_i / 6'd10);
        ones_o = 4'(value_i % 6'd10);
    end

endmodule

// File: rtl/seg7_display_scanner.sv
// 4-digit multiplexed 7-segment scanner with anti-ghost dead cycle; optional mode blink (SEG7_BLINK_EN).
// Latency: an/seg/dp are registered, one clk after the prescaler/digit index they reflect.
// Backpressure: none; inputs are snapshotted once per frame and may change freely.
module seg7_display_scanner
    import clock_display_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            hours_fsm,
    input  logic [5:0]            minutes_fsm,
    input  logic                  set_time_en,
    input  logic                  set_alarm_en,
    input  logic                  alarm_sound,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int              PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [6:0]      SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic            DP_OFF     = (SEG_ACTIVE_LOW != 0);

    logic [PW-1:0]         presc_q, presc_d;
    digit_idx_t            idx_q, idx_d;
    logic                  first_q;
    logic [5:0]            hours_q, minutes_q;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic                  slot_end;
    logic                  frame_end;
    logic                  snap_en;
    logic                  blank;
    logic [2:0]            hr_tens, min_tens;
    logic [3:0]            hr_ones, min_ones;
    logic [3:0]            digit;
    logic [6:0]            lit_seg;
    logic                  lit_dp;

    assign slot_end  = (presc_q == PRESC_LAST);
    assign frame_end = slot_end && (idx_q == 2'd3);
    // The first edge after reset loads a fresh snapshot so frame 0 is not stale zeros
    assign snap_en   = frame_end | first_q;

    seg7_bin2dig u_hours_dig (
        .value_i (hours_q),
        .tens_o  (hr_tens),
        .ones_o  (hr_ones)
    );

    seg7_bin2dig u_minutes_dig (
        .value_i (minutes_q),
        .tens_o  (min_tens),
        .ones_o  (min_ones)
    );

`ifdef SEG7_BLINK_EN
    localparam int            FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] frame_q;
    logic          blink_phase_q;
    logic          mode_en;

    assign mode_en = set_time_en | set_alarm_en;

    // Blink phase flips every BLINK_FRAMES frames in a set mode; parked visible otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_q       <= '0;
            blink_phase_q <= 1'b0;
        end else if (!mode_en) begin
            frame_q       <= '0;
            blink_phase_q <= 1'b0;
        end else if (frame_end) begin
            if (frame_q == FRAME_LAST) begin
                frame_q       <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                frame_q <= frame_q + 1'b1;
            end
        end
    end

    // Live enable gates the blank so leaving set mode shows digits on the next cycle
    assign blank = mode_en & blink_phase_q;
`else
    logic unused_blink;
    assign unused_blink = &{1'b0, set_time_en, set_alarm_en, (BLINK_FRAMES > 0)};
    assign blank        = 1'b0;
`endif

    // Prescaler wraps every SCAN_DIV cycles and steps the digit slot
    always_comb begin
        presc_d = slot_end ? '0 : presc_q + 1'b1;
        idx_d   = slot_end ? idx_q + 1'b1 : idx_q;
    end

    // Pick the decimal digit for the current slot, rightmost minutes digit first
    always_comb begin
        digit = 4'd0;
        case (idx_q)
            2'd0:    digit = min_ones;
            2'd1:    digit = {1'b0, min_tens};
            2'd2:    digit = hr_ones;
            default: digit = {1'b0, hr_tens};
        endcase
    end

    // Next anode/segment/dp values; anodes all off for the first cycle of each slot
    always_comb begin
        an_d = '1;
        if (presc_q != '0) begin
            an_d[idx_q] = 1'b0;
        end
        lit_seg = seg_pattern(digit);
        lit_dp  = (idx_q == 2'd2) | alarm_sound;
        if (blank) begin
            lit_seg = 7'h00;
            lit_dp  = 1'b0;
        end
        seg_d = (SEG_ACTIVE_LOW != 0) ? ~lit_seg : lit_seg;
        dp_d  = (SEG_ACTIVE_LOW != 0) ? ~lit_dp  : lit_dp;
    end

    // Scan state, per-frame input snapshot and registered display outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q   <= '0;
            idx_q     <= '0;
            first_q   <= 1'b1;
            hours_q   <= '0;
            minutes_q <= '0;
            an_q      <= '1;
            seg_q     <= SEG_OFF;
            dp_q      <= DP_OFF;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            first_q <= 1'b0;
            if (snap_en) begin
                hours_q   <= hours_fsm;
                minutes_q <= minutes_fsm;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_display_scanner.sv
module tb_seg7_display_scanner;

    localparam int SD    = 4;
    localparam int BF    = 2;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] hours_fsm;
    logic [5:0] minutes_fsm;
    logic       set_time_en;
    logic       set_alarm_en;
    logic       alarm_sound;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: cycle number since reset release, frame snapshot, enabled frames
    int c;
    int snap_h;
    int snap_m;
    int en_frames;

    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    bit         exp_dead;
    int         exp_slot;

    seg7_display_scanner #(
        .SCAN_DIV       (SD),
        .BLINK_FRAMES   (BF),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hours_fsm    (hours_fsm),
        .minutes_fsm  (minutes_fsm),
        .set_time_en  (set_time_en),
        .set_alarm_en (set_alarm_en),
        .alarm_sound  (alarm_sound),
        .an           (an),
        .seg          (seg),
        .dp           (dp)
    );

    always #5 clk = ~clk;

    // Standard 7-segment shapes, {g,f,e,d,c,b,a}, 1 = lit
    function automatic logic [6:0] lit_pattern(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic model_reset();
        c         = 0;
        snap_h    = 0;
        snap_m    = 0;
        en_frames = 0;
    endtask

    // Advance one clock and work out what the display must show after that edge
    task automatic tick();
        int h, m, pos, d;
        bit al, en, blank;
        @(posedge clk);
        h   = int'(hours_fsm);
        m   = int'(minutes_fsm);
        al  = alarm_sound;
        en  = set_time_en | set_alarm_en;
        pos = c % SD;
        exp_slot = (c / SD) % 4;
        exp_dead = (pos == 0);
        exp_an   = exp_dead ? 4'b1111 : ~(4'b0001 << exp_slot);
        case (exp_slot)
            0:       d = snap_m % 10;
            1:       d = snap_m / 10;
            2:       d = snap_h % 10;
            default: d = snap_h / 10;
        endcase
`ifdef SEG7_BLINK_EN
        blank = en && (((en_frames / BF) % 2) == 1);
`else
        blank = 1'b0;
`endif
        exp_seg = blank ? 7'h7F : ~lit_pattern(d);
        exp_dp  = blank ? 1'b1 : !(exp_slot == 2 || al);
        if (!en) en_frames = 0;
        else if ((c % FRAME) == FRAME - 1) en_frames++;
        if (c == 0 || (c % FRAME) == FRAME - 1) begin
            snap_h = h;
            snap_m = m;
        end
        c++;
        #1;
    endtask

    task automatic align();
        for (int k = 0; k < FRAME && (c % FRAME) != 0; k++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        hours_fsm = 6'd12; minutes_fsm = 6'd34;
        set_time_en = 1'b0; set_alarm_en = 1'b0; alarm_sound = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an got %b need 1111", an); end
        n_tests++;
        if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got %h need 7f", seg); end
        n_tests++;
        if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp got %b need 1", dp); end
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        int dig[4];
        dig = '{4, 3, 2, 1};
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            n_tests++;
            if (an !== exp_an || (!exp_dead && (seg !== exp_seg || dp !== exp_dp))) begin
                n_fail++;
                $display("FAIL basic c=%0d an=%b/%b seg=%b/%b dp=%b/%b (got/need)", c - 1, an, exp_an, seg, exp_seg, dp, exp_dp);
            end
            if (k >= FRAME && (k % SD) != 0) begin
                n_tests++;
                if (an !== ~(4'b0001 << (k / SD - 4)) || seg !== ~lit_pattern(dig[k / SD - 4]) ||
                    dp !== ((k / SD - 4) != 2)) begin
                    n_fail++;
                    $display("FAIL basic_table k=%0d an=%b seg=%b dp=%b", k, an, seg, dp);
                end
            end
        end
    endtask

    task automatic test_mid_frame();
        int f0;
        int oldd[4];
        int newd[4];
        oldd = '{4, 3, 2, 1};
        newd = '{5, 3, 7, 4};
        align();
        f0 = c;
        for (int k = 0; k < SD + 2; k++) begin
            tick();
            n_tests++;
            if (an !== exp_an || (!exp_dead && (seg !== exp_seg || dp !== exp_dp))) begin
                n_fail++;
                $display("FAIL midframe_pre c=%0d an=%b/%b seg=%b/%b (got/need)", c - 1, an, exp_an, seg, exp_seg);
            end
        end
        minutes_fsm = 6'd35;
        hours_fsm   = 6'd47;
        for (int k = 0; k < 2 * FRAME - SD - 2; k++) begin
            tick();
            n_tests++;
            if (an !== exp_an || (!exp_dead && (seg !== exp_seg || dp !== exp_dp))) begin
                n_fail++;
                $display("FAIL midframe c=%0d an=%b/%b seg=%b/%b (got/need)", c - 1, an, exp_an, seg, exp_seg);
            end
            if (!exp_dead) begin
                n_tests++;
                if (seg !== ~lit_pattern((c - 1 >= f0 + FRAME) ? newd[exp_slot] : oldd[exp_slot])) begin
                    n_fail++;
                    $display("FAIL midframe_digit c=%0d slot=%0d seg=%b", c - 1, exp_slot, seg);
                end
            end
        end
    endtask

    task automatic test_max_value();
        int d63[4];
        d63 = '{0, 0, 3, 6};
        for (int pass = 0; pass < 2; pass++) begin
            align();
            hours_fsm   = (pass == 0) ? 6'd63 : 6'd0;
            minutes_fsm = 6'd0;
            for (int k = 0; k < 2 * FRAME; k++) begin
                tick();
                n_tests++;
                if (an !== exp_an || (!exp_dead && (seg !== exp_seg || dp !== exp_dp))) begin
                    n_fail++;
                    $display("FAIL maxval c=%0d an=%b/%b seg=%b/%b (got/need)", c - 1, an, exp_an, seg, exp_seg);
                end
                if (k >= FRAME && !exp_dead) begin
                    n_tests++;
                    if (seg !== ~lit_pattern((pass == 0) ? d63[exp_slot] : 0)) begin
                        n_fail++;
                        $display("FAIL maxval_digit pass=%0d slot=%0d seg=%b", pass, exp_slot, seg);
                    end
                end
            end
        end
    endtask

    task automatic test_alarm_dp();
        align();
        alarm_sound = 1'b1;
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (k == FRAME + SD + 1) alarm_sound = 1'b0;
            tick();
            n_tests++;
            if (an !== exp_an || (!exp_dead && (seg !== exp_seg || dp !== exp_dp))) begin
                n_fail++;
                $display("FAIL alarm c=%0d an=%b/%b dp=%b/%b (got/need)", c - 1, an, exp_an, dp, exp_dp);
            end
            if (!exp_dead) begin
                n_tests++;
                if (dp !== ((k < FRAME + SD + 1) ? 1'b0 : (exp_slot != 2))) begin
                    n_fail++;
                    $display("FAIL alarm_dp k=%0d slot=%0d dp=%b", k, exp_slot, dp);
                end
            end
        end
    endtask

    task automatic test_blink();
        int dark;
        bit want_dark;
        align();
        set_time_en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            dark = 0;
            for (int k = 0; k < FRAME; k++) begin
                tick();
                n_tests++;
                if (an !== exp_an || (!exp_dead && (seg !== exp_seg || dp !== exp_dp))) begin
                    n_fail++;
                    $display("FAIL blink c=%0d an=%b/%b seg=%b/%b dp=%b/%b (got/need)", c - 1, an, exp_an, seg, exp_seg, dp, exp_dp);
                end
                if (!exp_dead && seg === 7'h7F && dp === 1'b1) dark++;
            end
`ifdef SEG7_BLINK_EN
            want_dark = (f == 2 || f == 3);
`else
            want_dark = 1'b0;
`endif
            n_tests++;
            if (dark !== (want_dark ? 4 * (SD - 1) : 0)) begin
                n_fail++;
                $display("FAIL blink_frame f=%0d dark_cycles=%0d need %0d", f, dark, want_dark ? 4 * (SD - 1) : 0);
            end
        end
        for (int k = 0; k < SD + 2; k++) tick();
        set_time_en = 1'b0;
        tick();
        n_tests++;
        if (an !== exp_an || seg !== exp_seg || seg === 7'h7F || dp !== exp_dp) begin
            n_fail++;
            $display("FAIL blink_release an=%b/%b seg=%b/%b dp=%b/%b (got/need)", an, exp_an, seg, exp_seg, dp, exp_dp);
        end
    endtask

    task automatic test_async_reset();
        align();
        for (int k = 0; k < 2 * SD + 2; k++) tick();
        n_tests++;
        if (an !== 4'b1011) begin n_fail++; $display("FAIL arst_pre an=%b need 1011", an); end
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_immediate an=%b seg=%h dp=%b need 1111 7f 1", an, seg, dp);
        end
        repeat (2) @(posedge clk);
        #1;
        hours_fsm   = 6'd21;
        minutes_fsm = 6'd9;
        rst = 1'b1;
        model_reset();
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            n_tests++;
            if (an !== exp_an || (!exp_dead && (seg !== exp_seg || dp !== exp_dp))) begin
                n_fail++;
                $display("FAIL arst_after c=%0d an=%b/%b seg=%b/%b (got/need)", c - 1, an, exp_an, seg, exp_seg);
            end
            if (k == 1) begin
                n_tests++;
                if (an !== 4'b1110 || seg !== ~lit_pattern(9)) begin
                    n_fail++;
                    $display("FAIL arst_restart an=%b seg=%b need 1110 %b", an, seg, ~lit_pattern(9));
                end
            end
        end
    endtask

    task automatic test_random();
        int len;
        for (int it = 0; it < 50; it++) begin
            hours_fsm    = 6'($urandom_range(0, 63));
            minutes_fsm  = 6'($urandom_range(0, 63));
            alarm_sound  = ($urandom_range(0, 3) == 0);
            set_time_en  = ($urandom_range(0, 2) == 0);
            set_alarm_en = ($urandom_range(0, 3) == 0);
            len = $urandom_range(1, 40);
            for (int k = 0; k < len; k++) begin
                tick();
                n_tests++;
                if (an !== exp_an || (!exp_dead && (seg !== exp_seg || dp !== exp_dp))) begin
                    n_fail++;
                    $display("FAIL random it=%0d c=%0d an=%b/%b seg=%b/%b dp=%b/%b (got/need)", it, c - 1, an, exp_an, seg, exp_seg, dp, exp_dp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mid_frame();
        test_max_value();
        test_alarm_dp();
        test_blink();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
